// File: rtl/bm_sched.sv
// Branch metric scheduler for a rate-1/2 hard-decision Viterbi decoder.
// Accepts received symbol pairs, registers the four Hamming-distance
// branch metrics with step index and frame markers, and sequences each
// frame through RUN, DRAIN and a traceback handshake.
module bm_sched #(
   parameter int FRAME_LEN = 16,
   parameter int IDX_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [1:0]       rx_pair_i,
   output logic             bm_valid_o,
   input  logic             bm_ready_i,
   output logic [1:0]       bm_00_o,
   output logic [1:0]       bm_01_o,
   output logic [1:0]       bm_10_o,
   output logic [1:0]       bm_11_o,
   output logic [IDX_W-1:0] sym_idx_o,
   output logic             frame_first_o,
   output logic             frame_last_o,
   output logic             tb_start_o,
   input  logic             tb_done_i,
   output logic             busy_o
);

   // The accept counter must be able to hold FRAME_LEN itself, not just the
   // last index, because reaching FRAME_LEN is what closes the frame.
   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      TB    = 2'd3
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               tb_start_q;
   logic               bm_valid_q;
   logic [1:0]         bm00_q, bm01_q, bm10_q, bm11_q;
   logic [1:0]         bm00_d, bm01_d, bm10_d, bm11_d;
   logic [IDX_W-1:0]   sym_idx_q;
   logic               first_q, last_q;
   logic [CNT_W-1:0]   cnt_inc;
   logic               accept;
   logic               consume;

   assign consume = bm_valid_q && bm_ready_i;

   // Ready is forced low while reset is held so nothing is offered to a
   // block whose state is being cleared.
   assign in_ready_o = rst_n
                       && ((state_q == IDLE) || (state_q == RUN))
                       && (cnt_q < FULL_CNT)
                       && (!bm_valid_q || bm_ready_i);

   assign accept  = in_valid_i && in_ready_o;
   assign cnt_inc = cnt_q + CNT_W'(1);

   // Hamming distance of the incoming pair to each of the four symbols;
   // bit 0 of a symbol is compared with rx_pair_i[0], bit 1 with rx_pair_i[1].
   always_comb begin
      bm00_d = {1'b0,  rx_pair_i[0]} + {1'b0,  rx_pair_i[1]};
      bm01_d = {1'b0, ~rx_pair_i[0]} + {1'b0,  rx_pair_i[1]};
      bm10_d = {1'b0,  rx_pair_i[0]} + {1'b0, ~rx_pair_i[1]};
      bm11_d = {1'b0, ~rx_pair_i[0]} + {1'b0, ~rx_pair_i[1]};
   end

   // Frame sequencing: count accepts, drain the output register, then hand
   // off to traceback with a single-cycle registered start pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         tb_start_q <= 1'b0;
      end else begin
         tb_start_q <= 1'b0;
         case (state_q)
            IDLE, RUN: begin
               if (accept) begin
                  cnt_q   <= cnt_inc;
                  state_q <= (cnt_inc == FULL_CNT) ? DRAIN : RUN;
               end
            end
            DRAIN: begin
               if (!bm_valid_q || bm_ready_i) begin
                  state_q    <= TB;
                  tb_start_q <= 1'b1;
               end
            end
            TB: begin
               if (tb_done_i) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Output register: reload on every accept (even when the previous set is
   // consumed on the same edge), otherwise drop valid once consumed and keep
   // the last payload untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bm_valid_q <= 1'b0;
         bm00_q     <= '0;
         bm01_q     <= '0;
         bm10_q     <= '0;
         bm11_q     <= '0;
         sym_idx_q  <= '0;
         first_q    <= 1'b0;
         last_q     <= 1'b0;
      end else if (accept) begin
         bm_valid_q <= 1'b1;
         bm00_q     <= bm00_d;
         bm01_q     <= bm01_d;
         bm10_q     <= bm10_d;
         bm11_q     <= bm11_d;
         sym_idx_q  <= IDX_W'(cnt_q);
         first_q    <= (cnt_q == '0);
         last_q     <= (cnt_q == LAST_CNT);
      end else if (consume) begin
         bm_valid_q <= 1'b0;
      end
   end

   assign bm_valid_o    = bm_valid_q;
   assign bm_00_o       = bm00_q;
   assign bm_01_o       = bm01_q;
   assign bm_10_o       = bm10_q;
   assign bm_11_o       = bm11_q;
   assign sym_idx_o     = sym_idx_q;
   assign frame_first_o = first_q;
   assign frame_last_o  = last_q;
   assign tb_start_o    = tb_start_q;
   assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_bm_sched.sv
// Directed and randomized bench for bm_sched with a 4-pair frame.
module tb_bm_sched;

   logic       clk;
   logic       rst_n;
   logic       inValid;
   logic       inReady;
   logic [1:0] rxPair;
   logic       bmValid;
   logic       bmReady;
   logic [1:0] bm00, bm01, bm10, bm11;
   logic [7:0] symIdx;
   logic       frameFirst, frameLast;
   logic       tbStart;
   logic       tbDone;
   logic       busy;

   int checkCount = 0;
   int errorCount = 0;

   typedef struct {
      logic [1:0] rx;
      int         idx;
   } entry_t;

   entry_t pending[$];

   logic [1:0] rxTab  [0:3] = '{2'b00, 2'b11, 2'b01, 2'b10};
   int         expTab [0:3][0:3] = '{'{0, 1, 1, 2}, '{2, 1, 1, 0},
                                     '{1, 0, 2, 1}, '{1, 2, 0, 1}};

   bm_sched #(.FRAME_LEN(4), .IDX_W(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid_i   (inValid),
      .in_ready_o   (inReady),
      .rx_pair_i    (rxPair),
      .bm_valid_o   (bmValid),
      .bm_ready_i   (bmReady),
      .bm_00_o      (bm00),
      .bm_01_o      (bm01),
      .bm_10_o      (bm10),
      .bm_11_o      (bm11),
      .sym_idx_o    (symIdx),
      .frame_first_o(frameFirst),
      .frame_last_o (frameLast),
      .tb_start_o   (tbStart),
      .tb_done_i    (tbDone),
      .busy_o       (busy)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic applyStimulus(input logic v, input logic [1:0] rx,
                                input logic r, input logic d);
      inValid = v;
      rxPair  = rx;
      bmReady = r;
      tbDone  = d;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      checkCount++;
      assert (obs === exp) else begin
         errorCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkSet(input string tag, input int e00, input int e01,
                           input int e10, input int e11, input int idx,
                           input logic first, input logic last);
      checkOutput($sformatf("%s.valid", tag), bmValid, 1);
      checkOutput($sformatf("%s.bm00", tag), bm00, e00);
      checkOutput($sformatf("%s.bm01", tag), bm01, e01);
      checkOutput($sformatf("%s.bm10", tag), bm10, e10);
      checkOutput($sformatf("%s.bm11", tag), bm11, e11);
      checkOutput($sformatf("%s.idx", tag), symIdx, idx);
      checkOutput($sformatf("%s.first", tag), frameFirst, first);
      checkOutput($sformatf("%s.last", tag), frameLast, last);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput($sformatf("%s.inReady", tag), inReady, 0);
      checkOutput($sformatf("%s.bmValid", tag), bmValid, 0);
      checkOutput($sformatf("%s.busy", tag), busy, 0);
      checkOutput($sformatf("%s.tbStart", tag), tbStart, 0);
      checkOutput($sformatf("%s.symIdx", tag), symIdx, 0);
      checkOutput($sformatf("%s.bm00", tag), bm00, 0);
      checkOutput($sformatf("%s.bm01", tag), bm01, 0);
      checkOutput($sformatf("%s.bm10", tag), bm10, 0);
      checkOutput($sformatf("%s.bm11", tag), bm11, 0);
      checkOutput($sformatf("%s.first", tag), frameFirst, 0);
      checkOutput($sformatf("%s.last", tag), frameLast, 0);
   endtask

   function automatic logic [1:0] expMetric(input logic [1:0] rx, input logic [1:0] sym);
      return {1'b0, rx[0] ^ sym[0]} + {1'b0, rx[1] ^ sym[1]};
   endfunction

   // Directed scenarios followed by a randomized valid/ready soak.
   initial begin
      int cycles;
      int frames;
      int acceptsInFrame;
      entry_t e;

      rst_n = 1'b0;
      applyStimulus(0, 2'b00, 0, 0);
      #12;
      checkResetValues("reset");
      rst_n = 1'b1;

      // Streaming frame with valid and ready tied high.
      applyStimulus(1, rxTab[0], 1, 0);
      #1;
      checkOutput("stream.readyIdle", inReady, 1);
      checkOutput("stream.busyIdle", busy, 0);
      for (int i = 0; i < 4; i++) begin
         waitCycle();
         checkSet($sformatf("stream%0d", i), expTab[i][0], expTab[i][1],
                  expTab[i][2], expTab[i][3], i, (i == 0), (i == 3));
         checkOutput($sformatf("stream%0d.busy", i), busy, 1);
         if (i < 3) applyStimulus(1, rxTab[i+1], 1, 0);
         else       applyStimulus(0, 2'b00, 1, 0);
      end
      checkOutput("stream.readyDrain", inReady, 0);
      waitCycle();
      checkOutput("stream.tbStart", tbStart, 1);
      checkOutput("stream.validAfter", bmValid, 0);
      applyStimulus(0, 2'b00, 1, 1);
      waitCycle();
      checkOutput("stream.tbStartOnce", tbStart, 0);
      checkOutput("stream.busyDone", busy, 0);

      // Backpressure: hold the first set for three extra cycles.
      applyStimulus(1, 2'b11, 0, 0);
      waitCycle();
      checkSet("bp0", 2, 1, 1, 0, 0, 1, 0);
      applyStimulus(1, 2'b01, 0, 0);
      #1;
      checkOutput("bp.readyStall", inReady, 0);
      for (int k = 0; k < 3; k++) begin
         waitCycle();
         checkSet($sformatf("bpHold%0d", k), 2, 1, 1, 0, 0, 1, 0);
         checkOutput($sformatf("bpHold%0d.ready", k), inReady, 0);
      end
      applyStimulus(1, 2'b01, 1, 0);
      #1;
      checkOutput("bp.readyResume", inReady, 1);
      waitCycle();
      checkSet("bp1", 1, 0, 2, 1, 1, 0, 0);
      applyStimulus(1, 2'b10, 1, 0);
      waitCycle();
      checkSet("bp2", 1, 2, 0, 1, 2, 0, 0);
      applyStimulus(1, 2'b00, 1, 0);
      waitCycle();
      checkSet("bp3", 0, 1, 1, 2, 3, 0, 1);
      // tb_done already high when TB is entered.
      applyStimulus(0, 2'b00, 1, 1);
      waitCycle();
      checkOutput("sameDone.tbStart", tbStart, 1);
      checkOutput("sameDone.busy", busy, 1);
      waitCycle();
      checkOutput("sameDone.tbStartOnce", tbStart, 0);
      checkOutput("sameDone.idle", busy, 0);
      applyStimulus(0, 2'b00, 1, 0);

      // Frame boundary with valid held high and a slow traceback.
      applyStimulus(1, 2'b10, 1, 0);
      for (int i = 0; i < 4; i++) begin
         waitCycle();
         checkOutput($sformatf("fb%0d.idx", i), symIdx, i);
         checkOutput($sformatf("fb%0d.bm01", i), bm01, 2);
      end
      checkOutput("fb.readyDrain", inReady, 0);
      waitCycle();
      checkOutput("fb.tbStart", tbStart, 1);
      checkOutput("fb.readyTb", inReady, 0);
      for (int k = 0; k < 4; k++) begin
         waitCycle();
         checkOutput($sformatf("fbWait%0d.tbStart", k), tbStart, 0);
         checkOutput($sformatf("fbWait%0d.ready", k), inReady, 0);
         checkOutput($sformatf("fbWait%0d.busy", k), busy, 1);
      end
      applyStimulus(1, 2'b10, 1, 1);
      waitCycle();
      checkOutput("fb.idleBusy", busy, 0);
      checkOutput("fb.idleReady", inReady, 1);
      checkOutput("fb.idleValid", bmValid, 0);
      applyStimulus(1, 2'b01, 1, 0);
      waitCycle();
      checkSet("fbNext0", 1, 0, 2, 1, 0, 1, 0);
      waitCycle();
      checkSet("fbNext1", 1, 0, 2, 1, 1, 0, 0);

      // Mid-frame reset after two accepts.
      #2;
      rst_n = 1'b0;
      #1;
      checkResetValues("midReset");
      applyStimulus(0, 2'b00, 1, 1);
      waitCycle();
      checkOutput("midReset.heldBusy", busy, 0);
      rst_n = 1'b1;
      waitCycle();
      checkOutput("postReset.tbStart", tbStart, 0);
      checkOutput("postReset.busy", busy, 0);
      applyStimulus(1, 2'b11, 1, 1);
      for (int i = 0; i < 4; i++) begin
         waitCycle();
         checkSet($sformatf("postReset%0d", i), 2, 1, 1, 0, i, (i == 0), (i == 3));
         checkOutput($sformatf("postReset%0d.tbStart", i), tbStart, 0);
      end
      applyStimulus(0, 2'b00, 1, 1);
      waitCycle();
      checkOutput("postReset.tbStartFrame", tbStart, 1);
      waitCycle();
      checkOutput("postReset.idle", busy, 0);

      // Randomized valid/ready/done traffic with a pair scoreboard.
      cycles = 0;
      frames = 0;
      acceptsInFrame = 0;
      while (frames < 1000 && cycles < 60000) begin
         applyStimulus($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                       $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)));
         #2;
         if (tbStart) begin
            checkOutput("rand.framePairs", acceptsInFrame, 4);
            acceptsInFrame = 0;
            frames++;
         end
         if (bmValid && bmReady) begin
            if (pending.size() == 0) begin
               checkOutput("rand.queueDepth", pending.size(), 1);
            end else begin
               e = pending.pop_front();
               checkOutput("rand.bm00", bm00, expMetric(e.rx, 2'b00));
               checkOutput("rand.bm01", bm01, expMetric(e.rx, 2'b01));
               checkOutput("rand.bm10", bm10, expMetric(e.rx, 2'b10));
               checkOutput("rand.bm11", bm11, expMetric(e.rx, 2'b11));
               checkOutput("rand.idx", symIdx, e.idx);
               checkOutput("rand.first", frameFirst, (e.idx == 0));
               checkOutput("rand.last", frameLast, (e.idx == 3));
            end
         end
         if (inValid && inReady) begin
            e.rx  = rxPair;
            e.idx = acceptsInFrame;
            pending.push_back(e);
            acceptsInFrame++;
         end
         waitCycle();
         cycles++;
      end
      checkOutput("rand.framesDone", frames, 1000);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/bm_sched.md
BM_SCHED -- requirements
Module: bm_sched

Interface
REQ-001 Parameter FRAME_LEN, default 16, meaning: received symbol pairs per frame, including encoder tail pairs; legal range 2..255.
REQ-002 Parameter IDX_W, default 8, meaning: width of sym_idx; must satisfy 2**IDX_W >= FRAME_LEN.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; 0 resets all state immediately, release is synchronous to clk.
REQ-005 in_valid  input  1  rx_pair holds a valid received symbol pair.
REQ-006 in_ready  output  1  block accepts rx_pair this cycle.
REQ-007 rx_pair  input  2  received hard-decision bit pair; bit 0 first code bit, bit 1 second.
REQ-008 bm_valid  output  1  branch metric register holds a valid set.
REQ-009 bm_ready  input  1  ACS array consumes the metric set this cycle.
REQ-010 bm_00, bm_01, bm_10, bm_11  output  2 each  Hamming distance of the registered pair to expected symbols 00, 01, 10, 11; symbol bit 0 corresponds to rx_pair[0].
REQ-011 sym_idx  output  IDX_W  trellis step index of the metric set in the output register.
REQ-012 frame_first, frame_last  output  1 each  output set is step 0 / step FRAME_LEN-1.
REQ-013 tb_start  output  1  one-cycle pulse requesting traceback.
REQ-014 tb_done  input  1  traceback finished; sampled only in state TB.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, RUN, DRAIN, TB.
REQ-017 Transfers: input accepted when in_valid && in_ready; output consumed when bm_valid && bm_ready.
REQ-018 in_ready = (state is IDLE or RUN) && (accept count < FRAME_LEN) && (!bm_valid || bm_ready); combinational, with no dependency on in_valid.
REQ-019 IDLE -> RUN on an accepted input; that input is step 0.
REQ-020 RUN: each accepted input increments accept count; the accept making count == FRAME_LEN moves the FSM to DRAIN on the same edge.
REQ-021 DRAIN: in_ready = 0; move to TB on the edge where the output register becomes empty, either by a consume or because it is already empty.
REQ-022 TB: tb_start = 1 exactly in the first cycle in TB; stay in TB until tb_done = 1, then go to IDLE and clear accept count to 0.
REQ-023 tb_done in TB's first cycle is honoured: exit on that edge after the tb_start pulse.
REQ-024 Output register: on accept, load all four metrics, sym_idx = accept count before increment, and the frame_first/frame_last flags; set bm_valid.
REQ-025 Latency: metrics appear exactly one cycle after the accept edge.
REQ-026 Simultaneous consume and accept: register reloads and bm_valid stays 1, with no bubble.
REQ-027 Consume without accept: bm_valid clears.
REQ-028 bm_valid held while bm_ready = 0: bm_* and sym_idx stay stable.
REQ-029 Metric rule: bm_ab = (rx_pair[0] != b) + (rx_pair[1] != a) for symbol "ab" (a = bit 1, b = bit 0); 2-bit unsigned, range 0..2, no wrap possible.
REQ-030 At each step, bm_00 + bm_11 = 2 and bm_01 + bm_10 = 2.
REQ-031 When bm_valid = 0, bm_*, sym_idx and frame flags hold their last values; consumers must not sample them.
REQ-032 Inputs offered during DRAIN or TB are not accepted and are not lost: in_ready = 0 provides backpressure.
REQ-033 A frame with FRAME_LEN = 2 is legal: frame_first and frame_last fall on consecutive steps.

Reset
REQ-034 During rst = 0: state = IDLE, accept count = 0, bm_valid = 0, bm_* = 0, sym_idx = 0, frame_first = 0, frame_last = 0, tb_start = 0, busy = 0.
REQ-035 During rst = 0, in_ready = 0.
REQ-036 Reset asserted mid-frame or in TB aborts the frame; no tb_start is issued for it.
REQ-037 The first cycle after release behaves as IDLE.

Verification
REQ-038 Streaming frame: FRAME_LEN = 4, rx_pair 00, 11, 01, 10 with in_valid and bm_ready tied high -> (bm_00, bm_01, bm_10, bm_11) = (0,1,1,2), (2,1,1,0), (1,0,2,1), (1,2,0,1); sym_idx 0..3; frame_first at idx 0, frame_last at idx 3; tb_start one cycle after the last consume.
REQ-039 Backpressure: bm_ready = 0 for 3 cycles with bm_valid = 1 -> in_ready = 0, outputs stable, no input dropped or duplicated; resumes with zero bubbles.
REQ-040 Frame boundary: in_valid held high across the frame end with tb_done delayed 5 cycles -> in_ready = 0 from DRAIN until the cycle after the return to IDLE; the next accepted pair gets sym_idx 0 and frame_first = 1.
REQ-041 Same-cycle tb_done: tb_done = 1 in the first TB cycle -> tb_start pulses once and the FSM is in IDLE on the next cycle.
REQ-042 Mid-frame reset: rst = 0 after 2 of 4 accepts -> all outputs at reset values immediately; after release the next frame starts at sym_idx 0 and no tb_start is issued for the aborted frame.
REQ-043 Randomized valid/ready over 1000 frames -> accepted count per frame = FRAME_LEN and every metric set matches REQ-029.
